byte_sub_shift_row: RTL and testbench

Fused AES SubBytes + ShiftRows stage over the shared 32-entry `statemt` word memory. It runs as the round stage immediately downstream of AddRoundKey in the AES-256 encrypt datapath. It reads the 16 state bytes, applies the S-box, applies the row rotation, and writes the result back in place. It uses the same ap_start/ap_done/ap_idle/ap_ready block handshake and the same two-port `statemt` interface as the neighbouring round stages.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_sbox_rom.sv | 16 +
 rtl/byte_sub_shift_row.sv | 158 +++++++++++++++
 tb/tb_byte_sub_shift_row.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_pkg : state encoding, layout constants and S-box for AES stages
// Rev 1.0
// ------------------------------------------------------------------
package aes_pkg;

  localparam int NB     = 4;
  localparam int NBYTES = NB * NB;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_RD   = 5'b00010,
    S_RDL  = 5'b00100,
    S_WR   = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  // Source byte for ShiftRows: row r of column c comes from column (c+r) mod 4.
  function automatic logic [3:0] src(input logic [3:0] i);
    logic [1:0] row;
    logic [1:0] col;
    row = i[1:0];
    col = i[3:2] + i[1:0];
    return {col, row};
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage
`default_nettype wire

// File: rtl/aes_sbox_rom.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_sbox_rom : combinational AES S-box lookup
// Rev 1.0
// ------------------------------------------------------------------
module aes_sbox_rom
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX[din];

endmodule
`default_nettype wire

// File: rtl/byte_sub_shift_row.sv
`default_nettype none
// ------------------------------------------------------------------
// byte_sub_shift_row : in-place SubBytes + ShiftRows over statemt
// Rev 1.0
// ------------------------------------------------------------------
module byte_sub_shift_row
  import aes_pkg::*;
#(
  parameter int SW = 32
)
(
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          ap_start,
  output logic          ap_done,
  output logic          ap_idle,
  output logic          ap_ready,
  output logic [4:0]    statemt_address0,
  output logic          statemt_ce0,
  output logic          statemt_we0,
  output logic [SW-1:0] statemt_d0,
  input  logic [SW-1:0] statemt_q0,
  output logic [4:0]    statemt_address1,
  output logic          statemt_ce1,
  output logic          statemt_we1,
  output logic [SW-1:0] statemt_d1,
  input  logic [SW-1:0] statemt_q1
);

  state_t     r_state;
  logic [2:0] r_k;
  logic       r_ce;
  logic       r_we;
  logic       r_done;
  logic [4:0] r_addr0;
  logic [4:0] r_addr1;
  logic [7:0] r_d0;
  logic [7:0] r_d1;
  logic [7:0] r_sbuf [NBYTES];

  logic [7:0] w_sb0;
  logic [7:0] w_sb1;
  logic       w_cap;
  logic [2:0] w_cap_k;
  logic [2:0] w_nk;
  logic       unused_hi;

  assign unused_hi = ^{statemt_q0[SW-1:8], statemt_q1[SW-1:8]};

  aes_sbox_rom u_sbox0 (.din(statemt_q0[7:0]), .dout(w_sb0));
  aes_sbox_rom u_sbox1 (.din(statemt_q1[7:0]), .dout(w_sb1));

  // Read data lags the request by one cycle, so pair k lands during RD(k+1) or RDL.
  always_comb begin
    w_cap   = ((r_state == S_RD) && (r_k != 3'd0)) || (r_state == S_RDL);
    w_cap_k = (r_state == S_RDL) ? 3'd7 : (r_k - 3'd1);
    w_nk    = r_k + 3'd1;
  end

  always_ff @(posedge ap_clk) begin
    if (w_cap) begin
      r_sbuf[{w_cap_k, 1'b0}] <= w_sb0;
      r_sbuf[{w_cap_k, 1'b1}] <= w_sb1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_k     <= 3'd0;
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_addr0 <= 5'd0;
      r_addr1 <= 5'd0;
      r_d0    <= 8'd0;
      r_d1    <= 8'd0;
    end else begin
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_addr0 <= 5'd0;
      r_addr1 <= 5'd0;
      r_d0    <= 8'd0;
      r_d1    <= 8'd0;
      unique case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_state <= S_RD;
            r_k     <= 3'd0;
            r_ce    <= 1'b1;
            r_addr0 <= 5'd0;
            r_addr1 <= 5'd1;
          end
        end
        S_RD: begin
          if (r_k == 3'd7) begin
            r_state <= S_RDL;
            r_k     <= 3'd0;
          end else begin
            r_k     <= w_nk;
            r_ce    <= 1'b1;
            r_addr0 <= {1'b0, w_nk, 1'b0};
            r_addr1 <= {1'b0, w_nk, 1'b1};
          end
        end
        S_RDL: begin
          // First write pair sources bytes 0 and 5, both captured before this edge.
          r_state <= S_WR;
          r_k     <= 3'd0;
          r_ce    <= 1'b1;
          r_we    <= 1'b1;
          r_addr0 <= 5'd0;
          r_addr1 <= 5'd1;
          r_d0    <= r_sbuf[src(4'd0)];
          r_d1    <= r_sbuf[src(4'd1)];
        end
        S_WR: begin
          if (r_k == 3'd7) begin
            r_state <= S_DONE;
            r_k     <= 3'd0;
            r_done  <= 1'b1;
          end else begin
            r_k     <= w_nk;
            r_ce    <= 1'b1;
            r_we    <= 1'b1;
            r_addr0 <= {1'b0, w_nk, 1'b0};
            r_addr1 <= {1'b0, w_nk, 1'b1};
            r_d0    <= r_sbuf[src({w_nk, 1'b0})];
            r_d1    <= r_sbuf[src({w_nk, 1'b1})];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_k     <= 3'd0;
        end
      endcase
    end
  end

  // Reset blanks the memory port immediately so an aborted write-back stops this cycle.
  assign statemt_ce0      = r_ce & ~ap_rst;
  assign statemt_ce1      = r_ce & ~ap_rst;
  assign statemt_we0      = r_we & ~ap_rst;
  assign statemt_we1      = r_we & ~ap_rst;
  assign statemt_address0 = ap_rst ? 5'd0 : r_addr0;
  assign statemt_address1 = ap_rst ? 5'd0 : r_addr1;
  assign statemt_d0       = ap_rst ? '0 : {{(SW-8){1'b0}}, r_d0};
  assign statemt_d1       = ap_rst ? '0 : {{(SW-8){1'b0}}, r_d1};
  assign ap_done          = r_done & ~ap_rst;
  assign ap_ready         = r_done & ~ap_rst;
  assign ap_idle          = ((r_state == S_IDLE) || ap_rst) && !ap_start;

endmodule
`default_nettype wire

// File: tb/tb_byte_sub_shift_row.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_byte_sub_shift_row : directed and random checks against a GF(2^8) model
// Rev 1.0
// ------------------------------------------------------------------
module tb_byte_sub_shift_row;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [4:0]  a0, a1;
  logic        ce0, ce1, we0, we1;
  logic [31:0] d0, d1;
  logic [31:0] q0 = '0;
  logic [31:0] q1 = '0;

  logic [31:0] mem [32];
  logic [31:0] pre [32];
  logic [7:0]  cur [16];
  logic [7:0]  sbox_ref [256];
  int          wr_count = 0;
  int          bad_addr = 0;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  byte_sub_shift_row #(.SW(32)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .statemt_address0(a0), .statemt_ce0(ce0), .statemt_we0(we0),
    .statemt_d0(d0), .statemt_q0(q0),
    .statemt_address1(a1), .statemt_ce1(ce1), .statemt_we1(we1),
    .statemt_d1(d1), .statemt_q1(q1)
  );

  // Two-port synchronous RAM with one-cycle read latency.
  always @(posedge ap_clk) begin
    if ((ce0 && a0 >= 5'd16) || (ce1 && a1 >= 5'd16)) bad_addr = bad_addr + 1;
    if (ce0) begin
      if (we0) begin mem[a0] = d0; wr_count = wr_count + 1; end
      else q0 <= mem[a0];
    end
    if (ce1) begin
      if (we1) begin mem[a1] = d1; wr_count = wr_count + 1; end
      else q1 <= mem[a1];
    end
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic snapshot();
    for (int i = 0; i < 32; i++) pre[i] = mem[i];
    for (int i = 0; i < 16; i++) cur[i] = mem[i][7:0];
  endtask

  // One SubBytes+ShiftRows step on cur[], column-major layout.
  task automatic model_step();
    logic [7:0] nxt [16];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        nxt[r + 4*c] = sbox_ref[cur[r + 4*((c + r) % 4)]];
    for (int i = 0; i < 16; i++) cur[i] = nxt[i];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s_w%0d", tag, i), mem[i], {24'h0, cur[i]});
    for (int i = 16; i < 32; i++) check($sformatf("%s_hi%0d", tag, i), mem[i], pre[i]);
  endtask

  task automatic run_op(output int done_cyc, output int ready_cyc, output int done_cnt);
    @(negedge ap_clk); ap_start = 1'b1;
    @(negedge ap_clk); ap_start = 1'b0;
    done_cyc = -1; ready_cyc = -1; done_cnt = 0;
    for (int c = 1; c <= 25; c++) begin
      if (ap_done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (ap_ready && ready_cyc < 0) ready_cyc = c;
      @(negedge ap_clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, rc, dn, w0, viol_idle, viol_done, viol_ce, first_rd, done2;
    logic [7:0] fips_in  [16];
    logic [7:0] fips_out [16];
    fips_in  = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                 8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
    fips_out = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                 8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    build_sbox();
    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    // Reset behaviour
    ap_rst = 1'b1; ap_start = 1'b0;
    repeat (3) @(negedge ap_clk);
    check("rst_idle", 32'(ap_idle), 32'd1);
    check("rst_done", 32'(ap_done), 32'd0);
    check("rst_ce",   32'({ce0, ce1, we0, we1}), 32'd0);
    ap_start = 1'b1; #1;
    check("rst_idle_start", 32'(ap_idle), 32'd0);
    ap_start = 1'b0;
    @(negedge ap_clk); ap_rst = 1'b0;
    @(negedge ap_clk);
    check("post_rst_idle", 32'(ap_idle), 32'd1);
    check("post_rst_ready", 32'(ap_ready), 32'd0);

    // FIPS-197 round-1 vector
    for (int i = 0; i < 16; i++) mem[i] = {24'h0, fips_in[i]};
    snapshot();
    for (int i = 0; i < 16; i++) cur[i] = fips_out[i];
    w0 = wr_count;
    run_op(dc, rc, dn);
    check("fips_done_cyc", dc, 18);
    check("fips_ready_cyc", rc, 18);
    check("fips_done_cnt", dn, 1);
    check("fips_writes", wr_count - w0, 16);
    check_mem("fips");

    // Upper bits ignored, zero-extended write-back
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEADBE00;
    snapshot();
    model_step();
    w0 = wr_count;
    run_op(dc, rc, dn);
    for (int i = 0; i < 16; i++) check($sformatf("dead_w%0d", i), mem[i], 32'h63);
    check("dead_writes", wr_count - w0, 16);
    check("dead_bad_addr", bad_addr, 0);

    // Ramp bytes: specific mapping points plus full model
    for (int i = 0; i < 16; i++) mem[i] = 32'(i);
    snapshot();
    model_step();
    run_op(dc, rc, dn);
    check("ramp_a0", mem[0], 32'h63);
    check("ramp_a1", mem[1], 32'h6b);
    check("ramp_a4", mem[4], 32'hf2);
    check_mem("ramp");

    // Random states
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      snapshot();
      model_step();
      w0 = wr_count;
      run_op(dc, rc, dn);
      check($sformatf("rnd%0d_done_cyc", t), dc, 18);
      check($sformatf("rnd%0d_writes", t), wr_count - w0, 16);
      check_mem($sformatf("rnd%0d", t));
    end

    // Back-to-back with ap_start held high
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    snapshot();
    model_step();
    model_step();
    w0 = wr_count; viol_idle = 0; first_rd = -1; dc = -1; done2 = -1; dn = 0;
    @(negedge ap_clk); ap_start = 1'b1;
    @(negedge ap_clk);
    for (int c = 1; c <= 45; c++) begin
      if (c <= 37 && ap_idle) viol_idle++;
      if (ap_done) begin
        dn++;
        if (dc < 0) dc = c; else if (done2 < 0) done2 = c;
      end
      if (c > 18 && ce0 && first_rd < 0) first_rd = c;
      if (c == 20) ap_start = 1'b0;
      @(negedge ap_clk);
    end
    check("b2b_done1", dc, 18);
    check("b2b_rd2_start", first_rd, 20);
    check("b2b_done2", done2, 37);
    check("b2b_done_cnt", dn, 2);
    check("b2b_idle_low", viol_idle, 0);
    check("b2b_writes", wr_count - w0, 32);
    check_mem("b2b");

    // Reset in the middle of write-back
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    snapshot();
    model_step();
    for (int i = 4; i < 16; i++) cur[i] = pre[i][7:0];
    w0 = wr_count; dn = 0;
    @(negedge ap_clk); ap_start = 1'b1;
    @(negedge ap_clk); ap_start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 12) ap_rst = 1'b1;
      if (c == 13) begin
        ap_rst = 1'b0; #1;
        check("mrst_we", 32'({we0, we1}), 32'd0);
        check("mrst_idle", 32'(ap_idle), 32'd1);
      end
      if (c >= 12 && ap_done) dn++;
      @(negedge ap_clk);
    end
    check("mrst_no_done", dn, 0);
    check("mrst_writes", wr_count - w0, 4);
    for (int i = 0; i < 16; i++)
      check($sformatf("mrst_w%0d", i), {24'h0, mem[i][7:0]}, {24'h0, cur[i]});
    for (int i = 4; i < 16; i++)
      check($sformatf("mrst_full%0d", i), mem[i], pre[i]);

    // Long idle
    viol_idle = 0; viol_done = 0; viol_ce = 0;
    for (int c = 0; c < 100; c++) begin
      if (!ap_idle) viol_idle++;
      if (ap_done || ap_ready) viol_done++;
      if (ce0 || ce1) viol_ce++;
      @(negedge ap_clk);
    end
    check("idle_idle", viol_idle, 0);
    check("idle_done", viol_done, 0);
    check("idle_ce", viol_ce, 0);
    check("final_bad_addr", bad_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
